// File: rtl/elastic_join_alu_fork.sv
// elastic_join_alu_fork: joins two operand streams, applies an ALU op, eagerly forks the registered result.
module elastic_join_alu_fork #(
  parameter int DATA_WIDTH = 32,
  parameter int FORK_NUM   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            op,
  input  logic                  valid_input_a,
  output logic                  stop_input_a,
  input  logic [DATA_WIDTH-1:0] data_input_a,
  input  logic                  valid_input_b,
  output logic                  stop_input_b,
  input  logic [DATA_WIDTH-1:0] data_input_b,
  output logic [FORK_NUM-1:0]   valid_output,
  input  logic [FORK_NUM-1:0]   stop_output,
  output logic [DATA_WIDTH-1:0] data_output
);
  localparam int SW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_full;
  logic [FORK_NUM-1:0]   r_sent;
  logic [FORK_NUM-1:0]   w_done;
  logic                  w_all_done;
  logic                  w_fire;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [SW-1:0]         w_sh;
  assign w_sh         = data_input_b[SW-1:0];
  assign w_done       = r_sent | ~stop_output;
  assign w_all_done   = r_full & (&w_done);
  // reset_n in the fire term keeps both operand stops asserted during reset
  assign w_fire       = reset_n & valid_input_a & valid_input_b & (~r_full | w_all_done);
  assign stop_input_a = ~w_fire;
  assign stop_input_b = ~w_fire;
  assign valid_output = {FORK_NUM{r_full}} & ~r_sent;
  assign data_output  = r_data;
  always_comb begin
    w_alu = '0;
    case (op)
      4'd0: w_alu = data_input_a + data_input_b;
      4'd1: w_alu = data_input_a - data_input_b;
      4'd2: w_alu = data_input_a * data_input_b;
      4'd3: w_alu = data_input_a & data_input_b;
      4'd4: w_alu = data_input_a | data_input_b;
      4'd5: w_alu = data_input_a ^ data_input_b;
      4'd6: w_alu = data_input_a << w_sh;
      4'd7: w_alu = data_input_a >> w_sh;
      4'd8: w_alu = data_input_a;
      4'd9: w_alu = {{(DATA_WIDTH-1){1'b0}}, data_input_a < data_input_b};
      default: w_alu = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_full <= 1'b0;
      r_sent <= '0;
    end else begin
      if (w_fire) begin
        r_data <= w_alu;
        r_full <= 1'b1;
      end else if (w_all_done) begin
        r_full <= 1'b0;
      end
      r_sent <= w_all_done ? '0 : r_sent | (valid_output & ~stop_output);
    end
  end
endmodule

// File: tb/tb_elastic_join_alu_fork.sv
// tb_elastic_join_alu_fork: directed vectors, per-branch expected queues checked by an independent monitor.
module tb_elastic_join_alu_fork;
  logic        clk = 0;
  logic        reset_n;
  logic [3:0]  op;
  logic        valid_input_a, valid_input_b;
  logic        stop_input_a, stop_input_b;
  logic [31:0] data_input_a, data_input_b;
  logic [3:0]  valid_output;
  logic [3:0]  stop_output;
  logic [31:0] data_output;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [4][$];

  elastic_join_alu_fork #(.DATA_WIDTH(32), .FORK_NUM(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op),
    .valid_input_a(valid_input_a), .stop_input_a(stop_input_a), .data_input_a(data_input_a),
    .valid_input_b(valid_input_b), .stop_input_b(stop_input_b), .data_input_b(data_input_b),
    .valid_output(valid_output), .stop_output(stop_output), .data_output(data_output)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] e);
    for (int i = 0; i < 4; i++) exp_q[i].push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o, input logic [31:0] e);
    valid_input_a = 1; valid_input_b = 1;
    data_input_a = a; data_input_b = b; op = o;
    push(e);
  endtask

  task automatic idle;
    valid_input_a = 0; valid_input_b = 0;
  endtask

  // A branch transfers on the next edge when it shows valid and is not stopped.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 4; i++) begin
        if (valid_output[i] && !stop_output[i]) begin
          if (exp_q[i].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result branch %0d: got %h expected none", i, data_output);
          end else begin
            chk($sformatf("branch%0d_data", i), data_output, exp_q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] va [7];
  logic [31:0] vb [7];
  logic [3:0]  vo [7];
  logic [31:0] ve [7];

  initial begin
    reset_n = 0; op = 0; idle(); data_input_a = 0; data_input_b = 0; stop_output = 0;
    va = '{32'hF0F0_1234, 32'h1, 32'h8000_0000, 32'd3, 32'd5, 32'hAB, 32'h0001_0000};
    vb = '{32'h0FF0_FF00, 32'h8000_0000, 32'h21, 32'd5, 32'd3, 32'hCD, 32'h0001_0000};
    vo = '{4'd3, 4'd4, 4'd7, 4'd9, 4'd9, 4'd12, 4'd2};
    ve = '{32'h00F0_1200, 32'h8000_0001, 32'h4000_0000, 32'd1, 32'd0, 32'd0, 32'd0};
    #3;
    chk("rst_valid", {28'd0, valid_output}, 0);
    chk("rst_data", data_output, 0);
    chk("rst_stop_a", {31'd0, stop_input_a}, 1);
    chk("rst_stop_b", {31'd0, stop_input_b}, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    // ADD, no stalls
    drive(5, 7, 0, 12);
    @(negedge clk); chk("add_stop_a", {31'd0, stop_input_a}, 0);
    tick(); idle();
    @(negedge clk); chk("add_valid", {28'd0, valid_output}, 32'hF); chk("add_data", data_output, 12);
    tick();
    @(negedge clk); chk("add_one_cycle", {28'd0, valid_output}, 0);
    tick();
    // join wait
    valid_input_a = 1; data_input_a = 3; op = 2; valid_input_b = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("join_wait_stop_a", {31'd0, stop_input_a}, 1);
      tick();
    end
    valid_input_b = 1; data_input_b = 4; push(12);
    @(negedge clk); chk("join_fire_stop_a", {31'd0, stop_input_a}, 0); chk("join_fire_stop_b", {31'd0, stop_input_b}, 0);
    tick(); idle();
    @(negedge clk); chk("join_data", data_output, 12);
    tick();
    // partial fork
    stop_output = 4'b0101;
    drive(32'h10, 32'h99, 8, 32'h10);
    @(negedge clk); chk("pf_fire", {31'd0, stop_input_a}, 0);
    tick(); idle();
    @(negedge clk); chk("pf_valid1", {28'd0, valid_output}, 32'hF);
    tick();
    @(negedge clk); chk("pf_valid2", {28'd0, valid_output}, 32'h5);
    tick(); stop_output = 0;
    @(negedge clk); chk("pf_valid3", {28'd0, valid_output}, 32'h5); chk("pf_data", data_output, 32'h10);
    tick();
    @(negedge clk); chk("pf_valid4", {28'd0, valid_output}, 0);
    tick();
    // streaming, no bubbles
    for (int k = 0; k < 8; k++) begin
      drive(3, 5, 1, 32'hFFFF_FFFE);
      @(negedge clk);
      chk("stream_stop_a", {31'd0, stop_input_a}, 0);
      if (k > 0) chk("stream_valid", {28'd0, valid_output}, 32'hF);
      tick();
    end
    idle();
    @(negedge clk); chk("stream_last_valid", {28'd0, valid_output}, 32'hF);
    tick();
    @(negedge clk); chk("stream_end_valid", {28'd0, valid_output}, 0);
    tick();
    // other opcodes back to back
    for (int k = 0; k < 7; k++) begin
      drive(va[k], vb[k], vo[k], ve[k]);
      tick();
    end
    idle();
    repeat (2) tick();
    // stall then release
    stop_output = 4'hF;
    drive(9, 6, 5, 15);
    tick();
    drive(2, 3, 6, 16);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_stop_a", {31'd0, stop_input_a}, 1);
      chk("stall_data", data_output, 15);
      chk("stall_valid", {28'd0, valid_output}, 32'hF);
      tick();
    end
    stop_output = 0;
    @(negedge clk); chk("release_stop_a", {31'd0, stop_input_a}, 0);
    tick(); idle();
    @(negedge clk); chk("release_valid", {28'd0, valid_output}, 32'hF); chk("release_data", data_output, 16);
    tick();
    // reset mid-fork, branches 0 and 1 already served
    stop_output = 4'b1100;
    drive(7, 1, 0, 8);
    tick(); idle();
    tick();
    #1 reset_n = 0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    #1;
    chk("rstmid_valid", {28'd0, valid_output}, 0);
    chk("rstmid_data", data_output, 0);
    chk("rstmid_stop_a", {31'd0, stop_input_a}, 1);
    @(negedge clk); #1 reset_n = 1; stop_output = 0;
    drive(20, 22, 0, 42);
    @(posedge clk); #1 idle();
    @(negedge clk); chk("post_rst_valid", {28'd0, valid_output}, 32'hF);
    tick();
    repeat (2) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("branch%0d_drained", i), exp_q[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
